// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI responder shift engine, oversampling sclk/ss_n/mosi in the wb_clk domain.
// Ports:
//   wb_clk, reset          system clock, synchronous active-high reset
//   cpol, cpha, lsb_first  SPI mode and bit order, latched when a select begins
//   tx_data/valid/ready    holding-register handshake for the next word to send
//   rx_data, rx_valid      last received word and its one-cycle update pulse
//   tx_underrun            pulses when a word starts with no word waiting
//   busy                   high while selected
//   sclk, ss_n, mosi       asynchronous pins from the master
//   miso, miso_oe          data out and its tristate enable
`timescale 1ns/1ps
module spi_slave_core #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wb_clk,
    input  logic             reset,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             lsb_first,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_underrun,
    output logic             busy,
    input  logic             sclk,
    input  logic             ss_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic sclk_d, ss_d;
    logic sclk_s, ss_s, mosi_s;
    logic cpol_l, cpha_l, lsb_l;
    logic [WIDTH-1:0] hold, tx_sh, rx_sh, rx_next;
    logic hold_full, skip;
    logic [CW-1:0] bit_cnt;
    logic sclk_edge, lead, trail, ss_fall, ss_rise;
    logic enter, leave, do_sample, do_shift, word_done, word_start, handshake;

    always_ff @(posedge wb_clk) begin
        if (reset) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    always_comb begin
        sclk_edge  = sclk_s ^ sclk_d;
        lead       = sclk_edge & (sclk_d == cpol_l);
        trail      = sclk_edge & (sclk_s == cpol_l);
        ss_fall    = ss_d & ~ss_s;
        ss_rise    = ~ss_d & ss_s;
        enter      = (state == IDLE) & ss_fall;
        leave      = (state == ACTIVE) & ss_rise;
        // a deselect in the same cycle as an sclk edge wins; the edge is dropped
        do_sample  = (state == ACTIVE) & ~ss_rise & (cpha_l ? trail : lead);
        do_shift   = (state == ACTIVE) & ~ss_rise & (cpha_l ? lead : trail);
        word_done  = do_sample & (bit_cnt == CW'(WIDTH - 1));
        word_start = enter | word_done;
        handshake  = tx_valid & ~hold_full;
        rx_next    = lsb_l ? {mosi_s, rx_sh[WIDTH-1:1]} : {rx_sh[WIDTH-2:0], mosi_s};
        state_nxt  = enter ? ACTIVE : leave ? IDLE : state;
    end

    always_ff @(posedge wb_clk) begin
        if (reset) begin
            state       <= IDLE;
            cpol_l      <= 1'b0;
            cpha_l      <= 1'b0;
            lsb_l       <= 1'b0;
            hold        <= '0;
            hold_full   <= 1'b0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            bit_cnt     <= '0;
            skip        <= 1'b0;
        end else begin
            state       <= state_nxt;
            rx_valid    <= word_done;
            tx_underrun <= word_start & ~hold_full;
            // a handshake coinciding with a word start refills the holding register
            hold_full   <= handshake ? 1'b1 : word_start ? 1'b0 : hold_full;
            if (handshake)
                hold <= tx_data;
            if (enter) begin
                cpol_l <= cpol;
                cpha_l <= cpha;
                lsb_l  <= lsb_first;
            end
            // the first shift edge of a word holds bit 0: always for cpha=1, and for
            // cpha=0 only between back-to-back words (the edge after the final sample)
            if (word_start) begin
                tx_sh <= hold_full ? hold : '0;
                skip  <= enter ? cpha : 1'b1;
            end else if (do_shift) begin
                skip <= 1'b0;
                if (!skip)
                    tx_sh <= lsb_l ? {1'b0, tx_sh[WIDTH-1:1]} : {tx_sh[WIDTH-2:0], 1'b0};
            end else if (leave) begin
                tx_sh <= '0;
            end
            if (enter || leave)
                bit_cnt <= '0;
            else if (do_sample)
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            if (leave)
                rx_sh <= '0;
            else if (do_sample)
                rx_sh <= rx_next;
            if (word_done)
                rx_data <= rx_next;
        end
    end

    assign tx_ready = ~hold_full;
    assign busy     = (state == ACTIVE);
    assign miso_oe  = busy;
    assign miso     = busy & (lsb_l ? tx_sh[0] : tx_sh[WIDTH-1]);
endmodule
